fault_inject_sequencer: RTL and testbench

Read-modify-write controller that corrupts the stored codewords in one 64-bit codeword RAM before the decode pass. It walks every address, reads the word, and scans the valid codeword bits of the selected algorithm one per cycle. Each bit is flipped with probability set by the BER level, using an LFSR, and the word is written back. It sits between the test-engine FSM (start/done handshake) and the port-A side of the selected codeword RAM, and fills the injection phase of the benchmark.

---
 rtl/fault_inject_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_fault_inject_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fault_inject_sequencer.sv
// -----------------------------------------------------------------------------
// fault_inject_sequencer
//
// Read-modify-write controller that corrupts every codeword stored in one
// codeword RAM before the decode pass. For each address 0..DEPTH-1 it reads
// the word and scans the valid codeword bits of the selected algorithm, one
// bit per cycle. A bit is flipped whenever the low half of a 32-bit Galois
// LFSR falls below a threshold derived from the BER level. The word is then
// written back.
//
// Ports
//   clk          : system clock, rising edge
//   rst          : asynchronous active-high reset
//   start        : single-cycle pass request, honoured only in IDLE
//   alg_sel[1:0] : 0 = C-RNNS (61 bits), 1 = 3NRM (48), 2 = 2NRM (41), 3 = RS (48)
//   ber_lvl[3:0] : BER percent 0..10, larger values are clamped to 10
//   ram_addr     : RAM address (registered)
//   ram_rd_en    : RAM read strobe, data returns one cycle later on ram_dout
//   ram_dout     : RAM read data
//   ram_we       : RAM write strobe
//   ram_din      : RAM write-back data
//   busy         : high in every state except IDLE and DONE
//   done         : one-cycle pulse when the pass completes
//   inject_count : saturating number of bits flipped in the current/last pass
// -----------------------------------------------------------------------------
module fault_inject_sequencer #(
  parameter int          DEPTH     = 10000,
  parameter int          ADDR_W    = 14,
  parameter int          DATA_W    = 64,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2345
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        alg_sel,
  input  logic [3:0]        ber_lvl,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd_en,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  output logic              busy,
  output logic              done,
  output logic [31:0]       inject_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_SCAN,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [31:0]       LFSR_POLY = 32'h8020_0003;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [31:0]         lfsr;
  logic [15:0]         thr;
  logic [5:0]          last_idx;   // valid width minus one for the latched algorithm
  logic [5:0]          idx;
  logic [DATA_W-1:0]   word;

  logic                hit;
  logic [DATA_W-1:0]   flip_mask;
  logic [DATA_W-1:0]   scan_word;
  logic [31:0]         lfsr_next;
  logic [3:0]          ber_clamped;
  logic [5:0]          sel_last_idx;

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    hit          = (lfsr[15:0] < thr);
    flip_mask    = '0;
    if (hit) flip_mask[idx] = 1'b1;
    scan_word    = word ^ flip_mask;
    lfsr_next    = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_POLY : 32'h0);
    ber_clamped  = (ber_lvl > 4'd10) ? 4'd10 : ber_lvl;
    sel_last_idx = 6'd47;
    case (alg_sel)
      2'd0:    sel_last_idx = 6'd60;
      2'd1:    sel_last_idx = 6'd47;
      2'd2:    sel_last_idx = 6'd40;
      default: sel_last_idx = 6'd47;
    endcase
  end

  // Outputs are registered: each transition also sets the outputs that belong
  // to the state being entered, so they are valid for that whole cycle.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      addr         <= '0;
      lfsr         <= LFSR_SEED;
      thr          <= '0;
      last_idx     <= '0;
      idx          <= '0;
      word         <= '0;
      ram_addr     <= '0;
      ram_rd_en    <= 1'b0;
      ram_we       <= 1'b0;
      ram_din      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      inject_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_RD;
            addr         <= '0;
            lfsr         <= LFSR_SEED;
            thr          <= 16'(ber_clamped) * 16'd655;
            last_idx     <= sel_last_idx;
            inject_count <= '0;
            ram_addr     <= '0;
            ram_rd_en    <= 1'b1;
            busy         <= 1'b1;
          end
        end

        S_RD: begin
          ram_rd_en <= 1'b0;
          state     <= S_WAIT;
        end

        S_WAIT: begin
          word  <= ram_dout;
          idx   <= '0;
          state <= S_SCAN;
        end

        S_SCAN: begin
          word <= scan_word;
          lfsr <= lfsr_next;
          idx  <= idx + 6'd1;
          if (hit && (inject_count != 32'hFFFF_FFFF)) begin
            inject_count <= inject_count + 32'd1;
          end
          if (idx == last_idx) begin
            // The write data must include the flip decided in this last
            // scan cycle, hence scan_word rather than word.
            state    <= S_WR;
            ram_addr <= addr;
            ram_din  <= scan_word;
            ram_we   <= 1'b1;
          end
        end

        S_WR: begin
          ram_we <= 1'b0;
          if (addr == LAST_ADDR) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            addr      <= addr + 1'b1;
            ram_addr  <= addr + 1'b1;
            ram_rd_en <= 1'b1;
            state     <= S_RD;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state     <= S_IDLE;
          ram_rd_en <= 1'b0;
          ram_we    <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fault_inject_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fault_inject_sequencer
//
// Self-checking bench for fault_inject_sequencer with a 4-word behavioural RAM.
// A table of passes (algorithm, BER level, preload, expected per-word cycle
// count and done cycle) is applied in a loop; each pass is compared against a
// golden LFSR flip model. Hand-written sequences cover clamping,
// reproducibility and reset in the middle of a pass.
// -----------------------------------------------------------------------------
module tb_fault_inject_sequencer;

  localparam int          DEPTH  = 4;
  localparam int          ADDR_W = 14;
  localparam int          DATA_W = 64;
  localparam logic [31:0] SEED   = 32'hACE1_2345;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        alg_sel;
  logic [3:0]        ber_lvl;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd_en;
  logic [DATA_W-1:0] ram_dout;
  logic              ram_we;
  logic [DATA_W-1:0] ram_din;
  logic              busy;
  logic              done;
  logic [31:0]       inject_count;

  fault_inject_sequencer #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .LFSR_SEED(SEED)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .alg_sel     (alg_sel),
    .ber_lvl     (ber_lvl),
    .ram_addr    (ram_addr),
    .ram_rd_en   (ram_rd_en),
    .ram_dout    (ram_dout),
    .ram_we      (ram_we),
    .ram_din     (ram_din),
    .busy        (busy),
    .done        (done),
    .inject_count(inject_count)
  );

  always #5 clk = ~clk;

  // Behavioural RAM, 1-cycle read latency.
  logic [63:0] mem [DEPTH];
  logic [63:0] rd_q;
  always @(posedge clk) begin
    if (ram_rd_en) rd_q <= mem[ram_addr[1:0]];
    if (ram_we)    mem[ram_addr[1:0]] <= ram_din;
  end
  assign ram_dout = rd_q;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [63:0] pre_img [DEPTH];
  logic [63:0] exp_img [DEPTH];
  logic [31:0] exp_cnt;

  function automatic int width_of(input logic [1:0] a);
    case (a)
      2'd0:    return 61;
      2'd1:    return 48;
      2'd2:    return 41;
      default: return 48;
    endcase
  endfunction

  task automatic run_model(input logic [1:0] alg, input logic [3:0] ber);
    logic [31:0] l;
    logic [15:0] thr;
    int          w;
    w   = width_of(alg);
    thr = 16'((ber > 4'd10) ? 4'd10 : ber) * 16'd655;
    l   = SEED;
    exp_cnt = 0;
    for (int a = 0; a < DEPTH; a++) begin
      exp_img[a] = pre_img[a];
      for (int i = 0; i < w; i++) begin
        if (l[15:0] < thr) begin
          exp_img[a][i] = ~exp_img[a][i];
          exp_cnt++;
        end
        l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
      end
    end
  endtask

  task automatic preload(input bit zero_fill);
    for (int a = 0; a < DEPTH; a++) begin
      mem[a] = zero_fill ? 64'h0 : (64'hDEAD_BEEF_0F0F_A5A5 ^ (64'(a + 1) * 64'h0123_4567_89AB_CDEF));
    end
  endtask

  // ------------------------------------------------------------- one pass
  // Cycle numbering: the edge that accepts start is cycle 0; the first
  // negedge after it is sampled as cycle 1.
  task automatic run_pass(input logic [1:0] alg, input logic [3:0] ber, input bit mid_start,
                          input int exp_wc, input int exp_done);
    int done_cyc;
    int we_cnt;
    int w;
    w = width_of(alg);
    for (int a = 0; a < DEPTH; a++) pre_img[a] = mem[a];
    run_model(alg, ber);
    done_cyc = 0;
    we_cnt   = 0;
    @(negedge clk);
    alg_sel = alg;
    ber_lvl = ber;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    for (int n = 1; n <= 600 && done_cyc == 0; n++) begin
      if (n > 1) @(negedge clk);
      if (mid_start) start = (n == 20);
      if (n == 1) begin
        check("rd_en at cycle 1", 64'(ram_rd_en), 64'd1);
        check("busy at cycle 1", 64'(busy), 64'd1);
      end
      if (ram_we) begin
        check("rd_en with we", 64'(ram_rd_en), 64'd0);
        check("we address", 64'(ram_addr), 64'(we_cnt));
        check("we cycle", 64'(n), 64'((we_cnt + 1) * exp_wc));
        we_cnt++;
      end
      if (done) begin
        done_cyc = n;
        check("busy in done cycle", 64'(busy), 64'd0);
      end
    end
    start = 1'b0;
    if (done_cyc == 0) check("done timeout", 64'd0, 64'd1);
    check("done cycle", 64'(done_cyc), 64'(exp_done));
    check("we pulse count", 64'(we_cnt), 64'(DEPTH));
    @(negedge clk);
    check("done one cycle", 64'(done), 64'd0);
    check("busy after done", 64'(busy), 64'd0);
    check("inject_count", 64'(inject_count), 64'(exp_cnt));
    for (int a = 0; a < DEPTH; a++) begin
      check("ram word", mem[a], exp_img[a]);
      check("bits above width untouched", (mem[a] ^ pre_img[a]) >> w, 64'd0);
    end
  endtask

  // ---------------------------------------------------------------- table
  typedef struct {
    logic [1:0] alg;
    logic [3:0] ber;
    bit         zero_fill;
    bit         mid_start;
    int         exp_wc;     // cycles per word (W+3)
    int         exp_done;   // done cycle = DEPTH*(W+3)+1
  } vec_t;

  vec_t vecs [6];

  logic [63:0] save_img [DEPTH];
  logic [31:0] save_cnt;
  int          popc;

  initial begin
    vecs[0] = '{alg: 2'd2, ber: 4'd0,  zero_fill: 1'b0, mid_start: 1'b0, exp_wc: 44, exp_done: 177};
    vecs[1] = '{alg: 2'd2, ber: 4'd10, zero_fill: 1'b1, mid_start: 1'b0, exp_wc: 44, exp_done: 177};
    vecs[2] = '{alg: 2'd0, ber: 4'd10, zero_fill: 1'b0, mid_start: 1'b0, exp_wc: 64, exp_done: 257};
    vecs[3] = '{alg: 2'd1, ber: 4'd10, zero_fill: 1'b0, mid_start: 1'b1, exp_wc: 51, exp_done: 205};
    vecs[4] = '{alg: 2'd3, ber: 4'd10, zero_fill: 1'b1, mid_start: 1'b0, exp_wc: 51, exp_done: 205};
    vecs[5] = '{alg: 2'd2, ber: 4'd3,  zero_fill: 1'b0, mid_start: 1'b1, exp_wc: 44, exp_done: 177};

    rst     = 1'b1;
    start   = 1'b0;
    alg_sel = 2'd0;
    ber_lvl = 4'd0;
    rd_q    = '0;
    preload(1'b1);
    repeat (3) @(negedge clk);
    check("reset ram_addr", 64'(ram_addr), 64'd0);
    check("reset rd_en", 64'(ram_rd_en), 64'd0);
    check("reset we", 64'(ram_we), 64'd0);
    check("reset din", ram_din, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset inject_count", 64'(inject_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", 64'(busy), 64'd0);

    for (int v = 0; v < 6; v++) begin
      preload(vecs[v].zero_fill);
      run_pass(vecs[v].alg, vecs[v].ber, vecs[v].mid_start, vecs[v].exp_wc, vecs[v].exp_done);
      if (vecs[v].ber == 4'd0) check("ber0 no flips", 64'(inject_count), 64'd0);
      if (vecs[v].zero_fill) begin
        popc = 0;
        for (int a = 0; a < DEPTH; a++) popc += $countones(mem[a]);
        check("count equals popcount", 64'(inject_count), 64'(popc));
      end
    end

    // Clamp: level 15 behaves exactly like level 10, even across a reset.
    preload(1'b0);
    run_pass(2'd0, 4'd15, 1'b0, 64, 257);
    for (int a = 0; a < DEPTH; a++) save_img[a] = mem[a];
    save_cnt = inject_count;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    preload(1'b0);
    run_pass(2'd0, 4'd10, 1'b0, 64, 257);
    check("clamp count", 64'(inject_count), 64'(save_cnt));
    for (int a = 0; a < DEPTH; a++) check("clamp image", mem[a], save_img[a]);

    // Reproducibility: two back-to-back passes from the same preload.
    preload(1'b0);
    run_pass(2'd3, 4'd10, 1'b0, 51, 205);
    for (int a = 0; a < DEPTH; a++) save_img[a] = mem[a];
    save_cnt = inject_count;
    preload(1'b0);
    run_pass(2'd3, 4'd10, 1'b1, 51, 205);
    check("repeat count", 64'(inject_count), 64'(save_cnt));
    for (int a = 0; a < DEPTH; a++) check("repeat image", mem[a], save_img[a]);

    // Reset during SCAN of word 2 (alg 1: word 2 scans cycles 105..152).
    preload(1'b0);
    for (int a = 0; a < DEPTH; a++) pre_img[a] = mem[a];
    run_model(2'd1, 4'd10);
    @(negedge clk);
    alg_sel = 2'd1;
    ber_lvl = 4'd10;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    repeat (109) @(negedge clk);   // now at cycle 110
    check("busy before reset", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid reset ram_addr", 64'(ram_addr), 64'd0);
    check("mid reset rd_en", 64'(ram_rd_en), 64'd0);
    check("mid reset we", 64'(ram_we), 64'd0);
    check("mid reset din", ram_din, 64'd0);
    check("mid reset busy", 64'(busy), 64'd0);
    check("mid reset done", 64'(done), 64'd0);
    check("mid reset inject_count", 64'(inject_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check("word 0 written before reset", mem[0], exp_img[0]);
    check("word 1 written before reset", mem[1], exp_img[1]);
    check("word 2 untouched", mem[2], pre_img[2]);
    check("word 3 untouched", mem[3], pre_img[3]);
    run_pass(2'd1, 4'd10, 1'b0, 51, 205);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
